// File: rtl/obi_data_arbiter.sv
// N-master to 1-slave OBI data-bus arbiter.
// Features:
//  - round-robin or fixed-priority master selection;
//  - an address-phase lock that keeps the slave request stable until it is granted;
//  - a small response-routing FIFO that sends each response back to the master that issued it.
module obi_data_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    output logic [NUM_MASTERS-1:0]              m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]              m_rvalid_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
    output logic                                s_req_o,
    input  logic                                s_gnt_i,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic                                s_we_o,
    output logic [DATA_WIDTH/8-1:0]             s_be_o,
    output logic [DATA_WIDTH-1:0]               s_wdata_o,
    input  logic                                s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                err_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    // Unpacked views of the packed master buses
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

    // Registered state
    logic             locked_q,   locked_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             err_q,      err_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];

    logic             any_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             handshake;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] head_idx;
    logic             found;
    logic [IDX_W:0]   rr_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign addr_arr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]    = m_be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign wdata_arr[gi] = m_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign m_gnt_o[gi]    = handshake && (sel_idx == IDX_W'(gi));
            assign m_rvalid_o[gi] = pop && (head_idx == IDX_W'(gi));
            assign m_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i;
        end
    endgenerate

    assign any_req    = |m_req_i;
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    // A full FIFO blocks the request outright; a same-cycle pop does not bypass it
    assign s_req_o    = any_req && !fifo_full;
    assign handshake  = s_req_o && s_gnt_i;
    assign push       = handshake;
    assign pop        = s_rvalid_i && !fifo_empty;
    assign head_idx   = fifo_q[rd_ptr_q];

    assign s_addr_o      = s_req_o ? addr_arr[sel_idx]  : '0;
    assign s_we_o        = s_req_o ? m_we_i[sel_idx]    : 1'b0;
    assign s_be_o        = s_req_o ? be_arr[sel_idx]    : '0;
    assign s_wdata_o     = s_req_o ? wdata_arr[sel_idx] : '0;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    // Winner selection: the locked index wins; otherwise round-robin from rr_ptr or lowest index
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        rr_sum  = '0;
        if (locked_q) begin
            sel_idx = lock_idx_q;
        end else if (ARB_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_req_i[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                if (rr_sum >= (IDX_W+1)'(NUM_MASTERS)) rr_sum = rr_sum - (IDX_W+1)'(NUM_MASTERS);
                if (!found && m_req_i[rr_sum[IDX_W-1:0]]) begin
                    found   = 1'b1;
                    sel_idx = rr_sum[IDX_W-1:0];
                end
            end
        end
    end

    // Next-state for lock, rotation pointer, FIFO pointers/occupancy and the sticky error
    always_comb begin
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q | (s_rvalid_i & fifo_empty);

        if (handshake) begin
            locked_d = 1'b0;
        end else if (s_req_o) begin
            locked_d   = 1'b1;
            lock_idx_d = sel_idx;
        end

        if (handshake && (ARB_MODE == 0)) begin
            rr_ptr_d = (sel_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
        end

        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;

        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // State registers; reset empties the FIFO, so stale responses later flag an error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage holds the granted master index; validity is tracked by the pointers alone
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= sel_idx;
    end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Testbench for obi_data_arbiter (3 masters, 2 outstanding).
// The round-robin instance is driven by a vector table; routed responses are
// matched against a scoreboard queue. A fixed-priority instance shares the inputs.
module tb_obi_data_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NM-1:0]     m_req_i;
    logic [NM*AW-1:0]  m_addr_i;
    logic [NM-1:0]     m_we_i;
    logic [NM*DW/8-1:0] m_be_i;
    logic [NM*DW-1:0]  m_wdata_i;
    logic              s_gnt_i;
    logic              s_rvalid_i;
    logic [DW-1:0]     s_rdata_i;

    logic [NM-1:0]     m_gnt_o,    fp_gnt;
    logic [NM-1:0]     m_rvalid_o, fp_rvalid;
    logic [NM*DW-1:0]  m_rdata_o,  fp_rdata;
    logic              s_req_o,    fp_req;
    logic [AW-1:0]     s_addr_o,   fp_addr;
    logic              s_we_o,     fp_we;
    logic [DW/8-1:0]   s_be_o,     fp_be;
    logic [DW-1:0]     s_wdata_o,  fp_wdata;
    logic [1:0]        outstanding_o, fp_out;
    logic              err_o,      fp_err;

    obi_data_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(MO), .ARB_MODE(0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    obi_data_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(MO), .ARB_MODE(1)) dut_fp (
        .clk_i(clk), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_gnt_o(fp_gnt), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(fp_rvalid), .m_rdata_o(fp_rdata),
        .s_req_o(fp_req), .s_gnt_i(s_gnt_i), .s_addr_o(fp_addr), .s_we_o(fp_we),
        .s_be_o(fp_be), .s_wdata_o(fp_wdata), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(fp_out), .err_o(fp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [2:0]  e_gnt;
        int          e_sel;   // -1: no slave request expected
        logic [2:0]  e_rv;
        logic [1:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs [24];
    int   sb_q [$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic [2:0] req, logic gnt, logic rv, logic [31:0] rdata,
                                logic [2:0] e_gnt, int e_sel, logic [2:0] e_rv,
                                logic [1:0] e_out, logic e_err);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_sel = e_sel; v.e_rv = e_rv; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic [31:0] addr_of(int k);
        return 32'h800 * (k + 1);
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_vec(input int idx, input vec_t v);
        int id;
        @(negedge clk);
        m_req_i = v.req; s_gnt_i = v.gnt; s_rvalid_i = v.rv; s_rdata_i = v.rdata;
        #1;
        $display("vec %0d req=%b gnt_in=%b rv_in=%b -> m_gnt=%b s_req=%b addr=%0h m_rvalid=%b out=%0d err=%b",
                 idx, v.req, v.gnt, v.rv, m_gnt_o, s_req_o, s_addr_o, m_rvalid_o, outstanding_o, err_o);
        chk($sformatf("v%0d m_gnt", idx), m_gnt_o, v.e_gnt);
        chk($sformatf("v%0d s_req", idx), s_req_o, v.e_sel >= 0);
        chk($sformatf("v%0d s_addr", idx), s_addr_o, (v.e_sel >= 0) ? addr_of(v.e_sel) : 32'h0);
        chk($sformatf("v%0d s_wdata", idx), s_wdata_o,
            (v.e_sel >= 0) ? 32'hD000_0000 + v.e_sel : 32'h0);
        chk($sformatf("v%0d s_be_we", idx), {s_be_o, s_we_o},
            (v.e_sel >= 0) ? {4'b0001 << v.e_sel, v.e_sel == 1} : 5'b0);
        chk($sformatf("v%0d m_rvalid", idx), m_rvalid_o, v.e_rv);
        chk($sformatf("v%0d outstanding", idx), outstanding_o, v.e_out);
        chk($sformatf("v%0d err", idx), err_o, v.e_err);
        // Scoreboard: the oldest granted master must receive this response
        if (m_rvalid_o !== 3'b000) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d sb_route: got m_rvalid=%b expected no response", idx, m_rvalid_o);
            end else begin
                id = sb_q.pop_front();
                chk($sformatf("v%0d sb_route", idx), m_rvalid_o, 3'b001 << id);
                chk($sformatf("v%0d sb_rdata", idx), m_rdata_o[id*32 +: 32], v.rdata);
            end
        end
        if (v.e_gnt != 3'b000) sb_q.push_back(v.e_sel);
    endtask

    initial begin
        // Round-robin rotation, one response per cycle
        vecs[0]  = mk(3'b111, 1, 0, 32'h0,         3'b001,  0, 3'b000, 0, 0);
        vecs[1]  = mk(3'b111, 1, 1, 32'h1111_0001, 3'b010,  1, 3'b001, 1, 0);
        vecs[2]  = mk(3'b111, 1, 1, 32'h1111_0002, 3'b100,  2, 3'b010, 1, 0);
        vecs[3]  = mk(3'b111, 1, 1, 32'h1111_0003, 3'b001,  0, 3'b100, 1, 0);
        vecs[4]  = mk(3'b100, 1, 1, 32'h1111_0004, 3'b100,  2, 3'b001, 1, 0);
        vecs[5]  = mk(3'b000, 0, 1, 32'h1111_0005, 3'b000, -1, 3'b100, 1, 0);
        // Address-phase lock on master 1, master 0 joins while stalled
        vecs[6]  = mk(3'b010, 0, 0, 32'h0,         3'b000,  1, 3'b000, 0, 0);
        vecs[7]  = mk(3'b010, 0, 0, 32'h0,         3'b000,  1, 3'b000, 0, 0);
        vecs[8]  = mk(3'b010, 0, 0, 32'h0,         3'b000,  1, 3'b000, 0, 0);
        vecs[9]  = mk(3'b011, 0, 0, 32'h0,         3'b000,  1, 3'b000, 0, 0);
        vecs[10] = mk(3'b011, 1, 0, 32'h0,         3'b010,  1, 3'b000, 0, 0);
        vecs[11] = mk(3'b001, 1, 0, 32'h0,         3'b001,  0, 3'b000, 1, 0);
        // Full FIFO: no grant even with a same-cycle pop
        vecs[12] = mk(3'b100, 1, 0, 32'h0,         3'b000, -1, 3'b000, 2, 0);
        vecs[13] = mk(3'b100, 1, 1, 32'h2222_0001, 3'b000, -1, 3'b010, 2, 0);
        vecs[14] = mk(3'b100, 1, 0, 32'h0,         3'b100,  2, 3'b000, 1, 0);
        vecs[15] = mk(3'b000, 0, 1, 32'h2222_0002, 3'b000, -1, 3'b001, 2, 0);
        vecs[16] = mk(3'b000, 0, 1, 32'h2222_0003, 3'b000, -1, 3'b100, 1, 0);
        // Out-of-turn routing: master 2 then master 0
        vecs[17] = mk(3'b100, 1, 0, 32'h0,         3'b100,  2, 3'b000, 0, 0);
        vecs[18] = mk(3'b001, 1, 0, 32'h0,         3'b001,  0, 3'b000, 1, 0);
        vecs[19] = mk(3'b000, 0, 1, 32'hA5A5_A5A5, 3'b000, -1, 3'b100, 2, 0);
        vecs[20] = mk(3'b000, 0, 1, 32'h5A5A_5A5A, 3'b000, -1, 3'b001, 1, 0);
        // Spurious response sets the sticky error
        vecs[21] = mk(3'b000, 0, 1, 32'hDEAD_BEEF, 3'b000, -1, 3'b000, 0, 0);
        vecs[22] = mk(3'b000, 0, 0, 32'h0,         3'b000, -1, 3'b000, 0, 1);
        vecs[23] = mk(3'b001, 1, 0, 32'h0,         3'b001,  0, 3'b000, 0, 1);

        for (int k = 0; k < NM; k++) begin
            m_addr_i[k*AW +: AW]   = addr_of(k);
            m_wdata_i[k*DW +: DW]  = 32'hD000_0000 + k;
            m_be_i[k*4 +: 4]       = 4'b0001 << k;
            m_we_i[k]              = (k == 1);
        end
        m_req_i = '0; s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0;
        rst_i = 1'b1;
        #3;
        chk("reset outputs", {m_gnt_o, m_rvalid_o, s_req_o, s_addr_o, s_we_o, s_be_o, outstanding_o, err_o}, '0);
        chk("reset rdata/wdata", {m_rdata_o[63:0], s_wdata_o}, '0);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 24; i++) do_vec(i, vecs[i]);

        // Asynchronous reset mid-transaction with one response outstanding
        @(negedge clk);
        m_req_i = '0; s_gnt_i = 0; s_rvalid_i = 0;
        #1 chk("pre-reset outstanding", outstanding_o, 2'd1);
        #1 rst_i = 1'b1;
        #1;
        $display("async reset: out=%0d err=%b s_req=%b m_rvalid=%b", outstanding_o, err_o, s_req_o, m_rvalid_o);
        chk("async reset outputs", {m_gnt_o, m_rvalid_o, s_req_o, s_addr_o, outstanding_o, err_o}, '0);
        sb_q.delete();
        @(negedge clk) rst_i = 1'b0;
        // The in-flight response now arrives and must be treated as unexpected
        @(negedge clk);
        s_rvalid_i = 1; s_rdata_i = 32'h3333_3333;
        #1 chk("stale rvalid dropped", m_rvalid_o, 3'b000);
        chk("stale err before edge", err_o, 1'b0);
        @(negedge clk);
        s_rvalid_i = 0;
        #1 chk("stale err set", err_o, 1'b1);
        $display("stale response: m_rvalid=%b err=%b", m_rvalid_o, err_o);

        // Fixed priority on the mode-1 instance
        @(negedge clk) rst_i = 1'b1;
        @(negedge clk) rst_i = 1'b0;
        begin
            logic [2:0] fp_req_v [5] = '{3'b101, 3'b101, 3'b101, 3'b100, 3'b000};
            logic       fp_gin   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            logic       fp_rvin  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            logic [2:0] fp_egnt  [5] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b000};
            logic [2:0] fp_erv   [5] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b100};
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                m_req_i = fp_req_v[i]; s_gnt_i = fp_gin[i]; s_rvalid_i = fp_rvin[i];
                s_rdata_i = 32'h4444_0000 + i;
                #1;
                $display("fp %0d req=%b -> gnt=%b rvalid=%b out=%0d", i, m_req_i, fp_gnt, fp_rvalid, fp_out);
                chk($sformatf("fp%0d gnt", i), fp_gnt, fp_egnt[i]);
                chk($sformatf("fp%0d rvalid", i), fp_rvalid, fp_erv[i]);
            end
        end
        @(negedge clk);
        m_req_i = '0; s_gnt_i = 0; s_rvalid_i = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/obi_data_arbiter.md
# obi_data_arbiter

Parametrised N-master to 1-slave OBI data-bus arbiter. It replaces the fixed two-master data crossbar that sits between the core LSU, the vector accelerator and the RAM data port. It supports a configurable master count, data width and arbitration mode, holds the address phase stable while a grant is pending, and tracks up to `MAX_OUTSTANDING` in-flight transactions so that each response is routed back to its originating master.

## Interface
Parameters:
- `NUM_MASTERS`, 2, number of master ports (2..8).
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; byte enables are `DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 2, depth of the response-routing FIFO (1..8).
- `ARB_MODE`, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (master 0 highest).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk_i` in 1: clock.
  - `rst_i` in 1: asynchronous active-high reset.
- Master side (bus `[k]` belongs to master k; packed buses put master k in slice k):
  - `m_req_i` in NUM_MASTERS: request per master.
  - `m_gnt_o` out NUM_MASTERS: grant per master.
  - `m_addr_i` in NUM_MASTERS*ADDR_WIDTH: packed addresses.
  - `m_we_i` in NUM_MASTERS: write enables.
  - `m_be_i` in NUM_MASTERS*DATA_WIDTH/8: packed byte enables.
  - `m_wdata_i` in NUM_MASTERS*DATA_WIDTH: packed write data.
  - `m_rvalid_o` out NUM_MASTERS: response valid per master.
  - `m_rdata_o` out NUM_MASTERS*DATA_WIDTH: read data; every slice carries `s_rdata_i`.
- Slave side:
  - `s_req_o` out 1: request to slave.
  - `s_gnt_i` in 1: grant from slave.
  - `s_addr_o` out ADDR_WIDTH: muxed address.
  - `s_we_o` out 1: muxed write enable.
  - `s_be_o` out DATA_WIDTH/8: muxed byte enables.
  - `s_wdata_o` out DATA_WIDTH: muxed write data.
  - `s_rvalid_i` in 1: response valid from slave.
  - `s_rdata_i` in DATA_WIDTH: read data from slave.
- Status:
  - `outstanding_o` out $clog2(MAX_OUTSTANDING+1): number of granted transactions without a response yet.
  - `err_o` out 1: sticky flag, set by an unexpected response.

## Operation
- **Selection.**
  - Unlocked: the winner is picked combinationally among asserted `m_req_i`.
  - Mode 0: search starts at `rr_ptr` and wraps modulo NUM_MASTERS.
  - Mode 1: lowest index wins.
- **Slave request.** `s_req_o = |m_req_i && !fifo_full`. `s_addr_o`, `s_we_o`, `s_be_o` and `s_wdata_o` are muxed from the selected master. When `s_req_o` is 0, these signals are 0.
- **Lock.**
  - If `s_req_o` = 1 and `s_gnt_i` = 0 at a clock edge, the selected index is registered and `locked` is set.
  - While locked, the selection is the locked index, regardless of new higher-priority requests.
  - The lock is cleared on the handshake cycle.
- **Handshake** (`s_req_o && s_gnt_i`):
  - `m_gnt_o[sel]` = 1 in the same cycle; all other bits are 0.
  - `sel` is pushed into the response FIFO.
  - In mode 0, `rr_ptr` becomes (sel+1) mod NUM_MASTERS.
- **Full FIFO.** When `fifo_full`, `s_req_o` = 0 and no grant is issued, even if a pop occurs in the same cycle (push is blocked on full, no bypass).
- **Response.**
  - On `s_rvalid_i` with the FIFO non-empty, `m_rvalid_o[head]` = 1 in the same cycle and the head is popped.
  - On `s_rvalid_i` with the FIFO empty, the response is dropped, no `m_rvalid_o` bit is asserted, and `err_o` is set until reset.
- **Simultaneous push and pop** (not full): both take effect and `outstanding_o` is unchanged.
- **Counter.** `outstanding_o` equals the FIFO occupancy. Pointers wrap modulo MAX_OUTSTANDING.
- **Reset** (asynchronous, any time, including mid-transaction):
  - FIFO emptied, `rr_ptr` = 0, `locked` = 0, `err_o` = 0, `outstanding_o` = 0.
  - Responses that were in flight before reset are afterwards treated as unexpected and set `err_o`.

## Timing
- Reset value of all outputs is 0. Combinational outputs are 0 as long as all inputs are 0.
- Request path: `m_req_i` → `s_req_o` and `s_gnt_i` → `m_gnt_o` are combinational, zero added latency.
- Response path: `s_rvalid_i` → `m_rvalid_o` is combinational, zero added latency.
- Registered state: `rr_ptr`, `locked`, locked index, FIFO contents and pointers, `err_o`. All update on the rising `clk_i` edge.
- Throughput: one grant per cycle, so back-to-back grants to different masters are allowed.
- A response may arrive in the cycle after its grant at the earliest.
- OBI rule required of masters: `m_req_i` and its attributes stay stable until `m_gnt_o`. The arbiter guarantees the same rule on the slave side via the lock.

## Test plan
- **Round-robin rotation.** Mode 0, NUM_MASTERS=3, all masters request continuously, `s_gnt_i` = 1 and `s_rvalid_i` one cycle later → grants alternate 0,1,2,0,1,2 and `outstanding_o` never exceeds 1.
- **Fixed priority.** Mode 1, masters 0 and 2 both request → master 0 is granted every cycle and master 2 only after master 0 drops its request.
- **Address-phase lock.** Master 1 requests, `s_gnt_i` = 0 for 3 cycles, master 0 then also requests → `s_addr_o` stays at master 1's address (e.g. 0x1000) until the grant; master 0 is granted the next cycle.
- **Full FIFO.** MAX_OUTSTANDING=2: two grants with no responses → `outstanding_o`=2 and `s_req_o`=0 in the cycle the third request arrives; one `s_rvalid_i` → `s_req_o` reasserts the following cycle.
- **Out-of-turn response routing.** Grant to master 2, then master 0; responses with rdata 0xA5A5A5A5 then 0x5A5A5A5A → `m_rvalid_o` = 3'b100 then 3'b001, and the rdata slices match.
- **Spurious response and reset.** `s_rvalid_i` with the FIFO empty → `err_o`=1 and no `m_rvalid_o`. `rst_i` asserted mid-transaction with `outstanding_o`=1 → all outputs 0 immediately.
